// File: rtl/button_event_decoder.sv
// button_event_decoder
// ---------------------------------------------------------------------------
// Purpose: turns the clean one-cycle press/release pulses from the push-button
// debouncer into gesture events: short press, long press, double click, and a
// long-hold status level. The application FSMs use these events and do not
// have to time button gestures themselves.
//
// Optional feature macro: AUTO_REPEAT_EN
//   defined   -> while long-held, PB_repeat_pulse ticks every REPEAT_CYCLES
//   undefined -> PB_repeat_pulse is tied 0 and the LONG timer saturates
//
// Ports:
//   clk                in   base clock
//   rst                in   asynchronous active-high reset (discards gesture)
//   PB_pressed_pulse   in   one-cycle clean press event
//   PB_released_pulse  in   one-cycle clean release event
//   PB_short_pulse     out  one-cycle: short press completed
//   PB_long_pulse      out  one-cycle: long-press threshold reached
//   PB_double_pulse    out  one-cycle: double click completed
//   PB_long_status     out  level: button held past long threshold
//   PB_repeat_pulse    out  one-cycle auto-repeat tick
// ---------------------------------------------------------------------------
module button_event_decoder #(
  parameter int LONG_CYCLES   = 1000,
  parameter int DCLICK_CYCLES = 300,
  parameter int REPEAT_CYCLES = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic PB_pressed_pulse,
  input  logic PB_released_pulse,
  output logic PB_short_pulse,
  output logic PB_long_pulse,
  output logic PB_double_pulse,
  output logic PB_long_status,
  output logic PB_repeat_pulse
);

  localparam int MAX_LD  = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
  localparam int MAX_ALL = (MAX_LD > REPEAT_CYCLES) ? MAX_LD : REPEAT_CYCLES;
  localparam int TW      = $clog2(MAX_ALL) + 1;

  localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] DCLICK_LAST = TW'(DCLICK_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_next;
  logic            w_short;
  logic            w_long;
  logic            w_double;
  logic            w_repeat;
  logic            w_wrap;

  logic            r_short;
  logic            r_long;
  logic            r_double;
  logic            r_status;
  logic            r_repeat;

  // Next-state and event decode. Only the input that matters in the current
  // state is looked at, so a release always beats the long timeout in PRESS1
  // and a press always beats the double-click timeout in WAIT2.
  always_comb begin
    w_next   = r_state;
    w_short  = 1'b0;
    w_long   = 1'b0;
    w_double = 1'b0;
    w_repeat = 1'b0;
    w_wrap   = 1'b0;
    case (r_state)
      IDLE: begin
        if (PB_pressed_pulse) w_next = PRESS1;
      end
      PRESS1: begin
        if (PB_released_pulse) begin
          w_next = WAIT2;
        end else if (r_timer == LONG_LAST) begin
          w_next = LONG;
          w_long = 1'b1;
        end
      end
      WAIT2: begin
        if (PB_pressed_pulse) begin
          w_next = PRESS2;
        end else if (r_timer == DCLICK_LAST) begin
          w_next  = IDLE;
          w_short = 1'b1;
        end
      end
      PRESS2: begin
        if (PB_released_pulse) begin
          w_next   = IDLE;
          w_double = 1'b1;
        end
      end
      LONG: begin
        if (PB_released_pulse) begin
          w_next = IDLE;
        end
`ifdef AUTO_REPEAT_EN
        else if (r_timer == REPEAT_LAST) begin
          w_wrap   = 1'b1;
          w_repeat = 1'b1;
        end
`endif
      end
      default: w_next = IDLE;
    endcase
  end

  // Timer restarts on every state change (and on an auto-repeat wrap);
  // otherwise it counts up and sticks at all-ones instead of wrapping.
  always_comb begin
    w_timer_next = r_timer;
    if ((w_next != r_state) || w_wrap) begin
      w_timer_next = '0;
    end else if (r_timer != '1) begin
      w_timer_next = r_timer + 1'b1;
    end
  end

  // State, timer and all outputs are registered together, so each event
  // appears in the cycle after the condition that produced it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_status <= 1'b0;
      r_repeat <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_timer  <= w_timer_next;
      r_short  <= w_short;
      r_long   <= w_long;
      r_double <= w_double;
      r_status <= (w_next == LONG);
      r_repeat <= w_repeat;
    end
  end

  assign PB_short_pulse  = r_short;
  assign PB_long_pulse   = r_long;
  assign PB_double_pulse = r_double;
  assign PB_long_status  = r_status;
  assign PB_repeat_pulse = r_repeat;

endmodule

// File: tb/tb_button_event_decoder.sv
// Testbench for button_event_decoder.
// Each gesture is described by its press/release cycle numbers; expected
// output timelines are derived from those numbers with plain arithmetic and
// compared cycle by cycle against the DUT.
module tb_button_event_decoder;

  localparam int LONG_C   = 20;
  localparam int DCLICK_C = 10;
  localparam int REPEAT_C = 5;
  localparam int N        = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pbPress = 1'b0;
  logic pbRelease = 1'b0;
  logic shortPulse, longPulse, doublePulse, longStatus, repeatPulse;

  int vectors = 0;
  int miscompares = 0;

  bit inPress[N];
  bit inRelease[N];
  bit expShort[N];
  bit expLong[N];
  bit expDouble[N];
  bit expStatus[N];
  bit expRepeat[N];

  button_event_decoder #(
    .LONG_CYCLES(LONG_C),
    .DCLICK_CYCLES(DCLICK_C),
    .REPEAT_CYCLES(REPEAT_C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .PB_pressed_pulse(pbPress),
    .PB_released_pulse(pbRelease),
    .PB_short_pulse(shortPulse),
    .PB_long_pulse(longPulse),
    .PB_double_pulse(doublePulse),
    .PB_long_status(longStatus),
    .PB_repeat_pulse(repeatPulse)
  );

  always #5 clk = ~clk;

  // Build the input plan and expected timelines for one gesture whose first
  // press is at cycle 0. p2 < 0 means no second press.
  task planGesture(input int r1, input int p2, input int r2);
    for (int c = 0; c < N; c++) begin
      inPress[c] = 0; inRelease[c] = 0;
      expShort[c] = 0; expLong[c] = 0; expDouble[c] = 0;
      expStatus[c] = 0; expRepeat[c] = 0;
    end
    inPress[0] = 1;
    inRelease[r1] = 1;
    if (r1 <= LONG_C) begin
      if (p2 >= 0) begin
        inPress[p2] = 1;
        inRelease[r2] = 1;
        expDouble[r2 + 1] = 1;
      end else begin
        expShort[r1 + DCLICK_C + 1] = 1;
      end
    end else begin
      expLong[LONG_C + 1] = 1;
      for (int c = LONG_C + 1; c <= r1; c++) expStatus[c] = 1;
`ifdef AUTO_REPEAT_EN
      for (int c = LONG_C + 1 + REPEAT_C; c <= r1; c += REPEAT_C) expRepeat[c] = 1;
`endif
    end
  endtask

  // Play the plan: outputs are sampled 1 ns after each rising edge, then the
  // inputs for that cycle are driven.
  task applyStimulus(input string name);
    for (int c = 0; c < N; c++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (shortPulse !== expShort[c]) begin
        miscompares++;
        $display("[TB] FAIL %s short cycle %0d: got %b expected %b", name, c, shortPulse, expShort[c]);
      end
      vectors++;
      if (longPulse !== expLong[c]) begin
        miscompares++;
        $display("[TB] FAIL %s long cycle %0d: got %b expected %b", name, c, longPulse, expLong[c]);
      end
      vectors++;
      if (doublePulse !== expDouble[c]) begin
        miscompares++;
        $display("[TB] FAIL %s double cycle %0d: got %b expected %b", name, c, doublePulse, expDouble[c]);
      end
      vectors++;
      if (longStatus !== expStatus[c]) begin
        miscompares++;
        $display("[TB] FAIL %s status cycle %0d: got %b expected %b", name, c, longStatus, expStatus[c]);
      end
      vectors++;
      if (repeatPulse !== expRepeat[c]) begin
        miscompares++;
        $display("[TB] FAIL %s repeat cycle %0d: got %b expected %b", name, c, repeatPulse, expRepeat[c]);
      end
      vectors++;
      if ($countones({shortPulse, longPulse, doublePulse, repeatPulse}) > 1) begin
        miscompares++;
        $display("[TB] FAIL %s onehot cycle %0d: got %b expected at most one set", name, c,
                 {shortPulse, longPulse, doublePulse, repeatPulse});
      end
      pbPress = inPress[c];
      pbRelease = inRelease[c];
    end
    @(posedge clk);
    #1;
    pbPress = 0;
    pbRelease = 0;
  endtask

  task test_reset;
    rst = 1;
    #3;
    vectors++;
    if ({shortPulse, longPulse, doublePulse, longStatus, repeatPulse} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got %b expected 00000",
               {shortPulse, longPulse, doublePulse, longStatus, repeatPulse});
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({shortPulse, longPulse, doublePulse, longStatus, repeatPulse} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_held: got %b expected 00000",
               {shortPulse, longPulse, doublePulse, longStatus, repeatPulse});
    end
    @(negedge clk);
    rst = 0;
  endtask

  task test_short;
    planGesture(5, -1, 0);
    applyStimulus("short");
  endtask

  task test_long;
    planGesture(40, -1, 0);
    applyStimulus("long");
  endtask

  task test_double;
    planGesture(4, 8, 12);
    applyStimulus("double");
  endtask

  task test_boundary;
    planGesture(LONG_C, -1, 0);
    applyStimulus("tie_long");
    planGesture(LONG_C + 1, -1, 0);
    applyStimulus("first_long_cycle_release");
    planGesture(3, 3 + DCLICK_C, 3 + DCLICK_C + 4);
    applyStimulus("tie_dclick");
    planGesture(1, -1, 0);
    applyStimulus("min_hold");
  endtask

  task test_reset_mid;
    for (int c = 0; c <= 25; c++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (longStatus !== (c >= LONG_C + 1)) begin
        miscompares++;
        $display("[TB] FAIL midreset_status cycle %0d: got %b expected %b", c, longStatus, c >= LONG_C + 1);
      end
      vectors++;
      if (longPulse !== (c == LONG_C + 1)) begin
        miscompares++;
        $display("[TB] FAIL midreset_long cycle %0d: got %b expected %b", c, longPulse, c == LONG_C + 1);
      end
      pbPress = (c == 0);
    end
    #2;
    rst = 1;
    #1;
    vectors++;
    if (longStatus !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_drop: got %b expected 0", longStatus);
    end
    #2;
    rst = 0;
    for (int c = 26; c < 70; c++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({shortPulse, longPulse, doublePulse, longStatus, repeatPulse} !== 5'b0) begin
        miscompares++;
        $display("[TB] FAIL midreset_quiet cycle %0d: got %b expected 00000", c,
                 {shortPulse, longPulse, doublePulse, longStatus, repeatPulse});
      end
      pbRelease = (c == 30);
    end
    planGesture(6, -1, 0);
    applyStimulus("post_reset_short");
  endtask

  // Random gestures with ignored-input noise: extra presses while held and
  // extra releases while waiting for a second click.
  task test_random;
    int kind, r1, p2, r2, hi;
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      p2 = -1;
      r2 = 0;
      if (kind == 2) r1 = int'($urandom_range(LONG_C + 1, 50));
      else r1 = int'($urandom_range(1, LONG_C));
      if (kind == 1) begin
        p2 = r1 + int'($urandom_range(1, DCLICK_C));
        r2 = p2 + int'($urandom_range(1, 25));
      end
      planGesture(r1, p2, r2);
      inPress[$urandom_range(1, r1)] = 1;
      if (r1 <= LONG_C) begin
        hi = (p2 >= 0) ? p2 : r1 + DCLICK_C;
        inRelease[$urandom_range(r1 + 1, hi)] = 1;
      end
      if (p2 >= 0) inPress[$urandom_range(p2 + 1, r2)] = 1;
      applyStimulus($sformatf("random%0d_k%0d", i, kind));
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
